// File: rtl/led_seq_pkg.sv
// Shared constants, state encoding and width helper for the LED sequencer family.
package led_seq_pkg;

   localparam logic [1:0] MODE_ROR  = 2'd0;
   localparam logic [1:0] MODE_ROL  = 2'd1;
   localparam logic [1:0] MODE_PING = 2'd2;
   localparam logic [1:0] MODE_FILL = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   // Bits needed to hold values 0..value-1, never less than one bit.
   function automatic int width_of(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..STEP_CYC-1 and flags the terminal count as a tick.
module led_tick_gen
   import led_seq_pkg::*;
#(
   parameter int STEP_CYC = 2_500_000
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear,
   output logic tick
);

   localparam int CW = width_of(STEP_CYC);
   localparam logic [CW-1:0] LAST = CW'(STEP_CYC - 1);

   logic [CW-1:0] cnt_reg;

   // Free-running step counter, held at zero while cleared so a run starts on a full step.
   always_ff @(posedge CLK) begin
      if (RST || clear) begin
         cnt_reg <= '0;
      end else if (cnt_reg == LAST) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign tick = (cnt_reg == LAST) && !clear;

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: rotate right/left, ping-pong window and bar fill/drain.
module led_pattern_seq
   import led_seq_pkg::*;
#(
   parameter int N_LED     = 8,
   parameter int STEP_CYC  = 2_500_000,
   parameter int RUN_STEPS = 20,
   parameter int SEED_ONES = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             go,
   input  logic             stop,
   input  logic [1:0]       mode,
   output logic [N_LED-1:0] LED_Out,
   output logic             busy,
   output logic             done
);

   localparam int RW   = width_of(RUN_STEPS + 1);
   localparam int PW   = width_of(N_LED);
   localparam int LW   = width_of(N_LED + 1);
   localparam int PMAX = N_LED - SEED_ONES;

   localparam logic [RW-1:0]    RUN_LAST  = RW'((RUN_STEPS == 0) ? 0 : RUN_STEPS - 1);
   localparam logic [RW-1:0]    RUN_MAX   = {RW{1'b1}};
   localparam logic [PW-1:0]    POS_MAX   = PW'(PMAX);
   localparam logic [LW-1:0]    LVL_MAX   = LW'(N_LED);
   localparam logic [LW-1:0]    LVL_MIN   = LW'(1);
   localparam logic [N_LED-1:0] SEED_PAT  = {N_LED{1'b1}} >> (N_LED - SEED_ONES);
   localparam logic [N_LED-1:0] INIT_FILL = N_LED'(1);

   state_t           state_reg;
   logic [1:0]       mode_reg;
   logic [RW-1:0]    run_cnt_reg;
   logic [PW-1:0]    pos_reg;
   logic             pos_dir_reg;
   logic [LW-1:0]    level_reg;
   logic             lvl_dir_reg;
   logic [N_LED-1:0] led_reg;
   logic             busy_reg;
   logic             done_reg;

   logic [PW-1:0]    pos_next;
   logic             pos_dir_next;
   logic [LW-1:0]    level_next;
   logic             lvl_dir_next;
   logic [N_LED-1:0] fill_led;
   logic [N_LED-1:0] adv_led;
   logic             tick;

   led_tick_gen #(
      .STEP_CYC(STEP_CYC)
   ) u_tick (
      .CLK  (CLK),
      .RST  (RST),
      .clear(state_reg != RUN),
      .tick (tick)
   );

   // Next window position and bar level; direction flips on reaching an endpoint
   // so each endpoint is displayed exactly once.
   always_comb begin
      pos_next     = pos_reg;
      pos_dir_next = pos_dir_reg;
      level_next   = level_reg;
      lvl_dir_next = lvl_dir_reg;
      if (PMAX != 0) begin
         if (!pos_dir_reg) begin
            pos_next = pos_reg + 1'b1;
            if (pos_next == POS_MAX) pos_dir_next = 1'b1;
         end else begin
            pos_next = pos_reg - 1'b1;
            if (pos_next == '0) pos_dir_next = 1'b0;
         end
      end
      if (!lvl_dir_reg) begin
         level_next = level_reg + 1'b1;
         if (level_next == LVL_MAX) lvl_dir_next = 1'b1;
      end else begin
         level_next = level_reg - 1'b1;
         if (level_next == LVL_MIN) lvl_dir_next = 1'b0;
      end
   end

   // Bar of the next level: bit gi is lit when the level exceeds gi.
   for (genvar gi = 0; gi < N_LED; gi++) begin : g_fill
      assign fill_led[gi] = (int'(level_next) > gi);
   end

   // Pattern shown after the next step, by latched mode.
   always_comb begin
      adv_led = led_reg;
      case (mode_reg)
         MODE_ROR:  adv_led = {led_reg[0], led_reg[N_LED-1:1]};
         MODE_ROL:  adv_led = {led_reg[N_LED-2:0], led_reg[N_LED-1]};
         MODE_PING: adv_led = SEED_PAT << pos_next;
         MODE_FILL: adv_led = fill_led;
         default:   adv_led = led_reg;
      endcase
   end

   // Control FSM with registered LED, busy and done outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg   <= IDLE;
         mode_reg    <= '0;
         run_cnt_reg <= '0;
         pos_reg     <= '0;
         pos_dir_reg <= 1'b0;
         level_reg   <= '0;
         lvl_dir_reg <= 1'b0;
         led_reg     <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               led_reg  <= '0;
               busy_reg <= 1'b0;
               done_reg <= 1'b0;
               if (go && !stop) begin
                  state_reg   <= RUN;
                  mode_reg    <= mode;
                  run_cnt_reg <= '0;
                  pos_reg     <= '0;
                  pos_dir_reg <= 1'b0;
                  level_reg   <= LVL_MIN;
                  lvl_dir_reg <= 1'b0;
                  busy_reg    <= 1'b1;
                  led_reg     <= (mode == MODE_FILL) ? INIT_FILL : SEED_PAT;
               end
            end
            RUN: begin
               if (stop) begin
                  state_reg <= IDLE;
                  led_reg   <= '0;
                  busy_reg  <= 1'b0;
               end else if (tick) begin
                  if ((RUN_STEPS != 0) && (run_cnt_reg == RUN_LAST)) begin
                     state_reg <= FINISH;
                     led_reg   <= '0;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                  end else begin
                     led_reg     <= adv_led;
                     pos_reg     <= pos_next;
                     pos_dir_reg <= pos_dir_next;
                     level_reg   <= level_next;
                     lvl_dir_reg <= lvl_dir_next;
                     if (run_cnt_reg != RUN_MAX) run_cnt_reg <= run_cnt_reg + 1'b1;
                  end
               end
            end
            FINISH: begin
               state_reg <= IDLE;
               led_reg   <= '0;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               led_reg   <= '0;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign LED_Out = led_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench: four sequencer instances, expected per-cycle outputs queued and popped.
module tb_led_pattern_seq;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       RST;
   logic       go    [4];
   logic       stop  [4];
   logic [1:0] mode  [4];
   logic [7:0] led_o [4];
   logic       busy_o[4];
   logic       done_o[4];

   typedef struct packed {
      logic [7:0] led;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t sb[$];
   int checks   = 0;
   int failures = 0;

   // 0: base params, 1: endless run, 2: ten steps, 3: full-width window
   led_pattern_seq #(.N_LED(8), .STEP_CYC(4), .RUN_STEPS(5), .SEED_ONES(4)) dut_a (
      .CLK(CLK), .RST(RST), .go(go[0]), .stop(stop[0]), .mode(mode[0]),
      .LED_Out(led_o[0]), .busy(busy_o[0]), .done(done_o[0]));
   led_pattern_seq #(.N_LED(8), .STEP_CYC(4), .RUN_STEPS(0), .SEED_ONES(4)) dut_b (
      .CLK(CLK), .RST(RST), .go(go[1]), .stop(stop[1]), .mode(mode[1]),
      .LED_Out(led_o[1]), .busy(busy_o[1]), .done(done_o[1]));
   led_pattern_seq #(.N_LED(8), .STEP_CYC(4), .RUN_STEPS(10), .SEED_ONES(4)) dut_c (
      .CLK(CLK), .RST(RST), .go(go[2]), .stop(stop[2]), .mode(mode[2]),
      .LED_Out(led_o[2]), .busy(busy_o[2]), .done(done_o[2]));
   led_pattern_seq #(.N_LED(8), .STEP_CYC(4), .RUN_STEPS(5), .SEED_ONES(8)) dut_d (
      .CLK(CLK), .RST(RST), .go(go[3]), .stop(stop[3]), .mode(mode[3]),
      .LED_Out(led_o[3]), .busy(busy_o[3]), .done(done_o[3]));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] led, input logic busy, input logic done, input int reps);
      exp_t e;
      e.led  = led;
      e.busy = busy;
      e.done = done;
      for (int k = 0; k < reps; k++) sb.push_back(e);
   endtask

   task automatic push_run(input logic [7:0] led, input int steps);
      push(led, 1'b1, 1'b0, 4 * steps);
   endtask

   // Compare n queued cycles against instance idx, advancing one clock after each.
   task automatic step_check(input int idx, input string tag, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty at cycle %0d observed=0x%02h expected=none", tag, k, led_o[idx]);
         end else begin
            e = sb.pop_front();
            $display("%s c%0d led=0x%02h busy=%0b done=%0b exp_led=0x%02h",
                     tag, k, led_o[idx], busy_o[idx], done_o[idx], e.led);
            chk($sformatf("%s.led.c%0d", tag, k), led_o[idx], e.led);
            chk($sformatf("%s.busy.c%0d", tag, k), {7'd0, busy_o[idx]}, {7'd0, e.busy});
            chk($sformatf("%s.done.c%0d", tag, k), {7'd0, done_o[idx]}, {7'd0, e.done});
         end
         @(posedge CLK); #1;
      end
   endtask

   task automatic start(input int idx, input logic [1:0] m);
      go[idx]   = 1'b1;
      mode[idx] = m;
      @(posedge CLK); #1;
      go[idx]   = 1'b0;
      mode[idx] = ~m;
   endtask

   initial begin
      RST = 1'b1;
      for (int i = 0; i < 4; i++) begin
         go[i] = 1'b0; stop[i] = 1'b0; mode[i] = 2'd0;
      end
      repeat (3) @(posedge CLK);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset.led%0d", i), led_o[i], 8'h00);
         chk($sformatf("reset.busy%0d", i), {7'd0, busy_o[i]}, 8'h00);
         chk($sformatf("reset.done%0d", i), {7'd0, done_o[i]}, 8'h00);
      end
      RST = 1'b0;
      @(posedge CLK); #1;

      // Rotate right
      start(0, 2'd0);
      push_run(8'h0F, 1); push_run(8'h87, 1); push_run(8'hC3, 1);
      push_run(8'hE1, 1); push_run(8'hF0, 1);
      push(8'h00, 1'b0, 1'b1, 1); push(8'h00, 1'b0, 1'b0, 2);
      step_check(0, "ror", 23);

      // Rotate left
      start(0, 2'd1);
      push_run(8'h0F, 1); push_run(8'h1E, 1); push_run(8'h3C, 1);
      push_run(8'h78, 1); push_run(8'hF0, 1);
      push(8'h00, 1'b0, 1'b1, 1); push(8'h00, 1'b0, 1'b0, 2);
      step_check(0, "rol", 23);

      // Ping-pong, endless run, stopped during the tenth pattern
      start(1, 2'd2);
      push_run(8'h0F, 1); push_run(8'h1E, 1); push_run(8'h3C, 1);
      push_run(8'h78, 1); push_run(8'hF0, 1); push_run(8'h78, 1);
      push_run(8'h3C, 1); push_run(8'h1E, 1); push_run(8'h0F, 1);
      push(8'h1E, 1'b1, 1'b0, 3);
      step_check(1, "ping", 38);
      stop[1] = 1'b1;
      step_check(1, "ping_stop", 1);
      stop[1] = 1'b0;
      push(8'h00, 1'b0, 1'b0, 6);
      step_check(1, "ping_after", 6);

      // Fill/drain
      start(2, 2'd3);
      push_run(8'h01, 1); push_run(8'h03, 1); push_run(8'h07, 1);
      push_run(8'h0F, 1); push_run(8'h1F, 1); push_run(8'h3F, 1);
      push_run(8'h7F, 1); push_run(8'hFF, 1); push_run(8'h7F, 1);
      push_run(8'h3F, 1);
      push(8'h00, 1'b0, 1'b1, 1); push(8'h00, 1'b0, 1'b0, 2);
      step_check(2, "fill", 43);

      // Interference: go mid-run ignored, reset aborts, fresh go restarts
      start(0, 2'd0);
      push_run(8'h0F, 1); push_run(8'h87, 1); push(8'hC3, 1'b1, 1'b0, 3);
      step_check(0, "intf", 6);
      go[0] = 1'b1; mode[0] = 2'd3;
      step_check(0, "intf_go", 1);
      go[0] = 1'b0;
      step_check(0, "intf", 3);
      RST = 1'b1;
      step_check(0, "intf_rst", 1);
      RST = 1'b0;
      push(8'h00, 1'b0, 1'b0, 3);
      step_check(0, "intf_idle", 3);
      start(0, 2'd0);
      push_run(8'h0F, 1); push_run(8'h87, 1); push_run(8'hC3, 1);
      push_run(8'hE1, 1); push_run(8'hF0, 1);
      push(8'h00, 1'b0, 1'b1, 1); push(8'h00, 1'b0, 1'b0, 1);
      step_check(0, "restart", 22);

      // go and stop together in IDLE
      go[0] = 1'b1; stop[0] = 1'b1; mode[0] = 2'd0;
      @(posedge CLK); #1;
      go[0] = 1'b0; stop[0] = 1'b0;
      push(8'h00, 1'b0, 1'b0, 3);
      step_check(0, "gostop", 3);

      // stop coincident with the final tick
      start(0, 2'd0);
      push_run(8'h0F, 1); push_run(8'h87, 1); push_run(8'hC3, 1);
      push_run(8'hE1, 1); push_run(8'hF0, 1);
      step_check(0, "lastStop", 19);
      stop[0] = 1'b1;
      step_check(0, "lastStop_edge", 1);
      stop[0] = 1'b0;
      push(8'h00, 1'b0, 1'b0, 3);
      step_check(0, "lastStop_after", 3);

      // Full-width window in ping-pong stays static
      start(3, 2'd2);
      push_run(8'hFF, 5);
      push(8'h00, 1'b0, 1'b1, 1); push(8'h00, 1'b0, 1'b0, 2);
      step_check(3, "static", 23);

      chk("sb_drain", 8'(sb.size()), 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
